// File: rtl/mul_pkg.sv
// Shared definitions for the sequential sign-magnitude multiplier:
// FSM encoding, default operand width and derived width helpers.
package mul_pkg;

    localparam int MAG_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int res_width(input int mag_w);
        return 2 * mag_w + 1;
    endfunction

    // Operands and results carry their sign in the bit just above the magnitude.
    function automatic int sign_idx(input int mag_w);
        return mag_w;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester that
// wins a tie and flips away from the winner whenever a grant is taken.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt,
    output logic       o_gnt_id
);

    logic ptr_q, ptr_d;

    always_comb begin
        o_gnt_id = 1'b0;
        o_gnt    = 2'b00;
        ptr_d    = ptr_q;
        case (i_req)
            2'b01:   o_gnt_id = 1'b0;
            2'b10:   o_gnt_id = 1'b1;
            2'b11:   o_gnt_id = ptr_q;
            default: o_gnt_id = 1'b0;
        endcase
        if (i_req != 2'b00) begin
            o_gnt = o_gnt_id ? 2'b10 : 2'b01;
        end
        if (i_advance) begin
            ptr_d = ~o_gnt_id;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mul_seq_sched.sv
// Shared shift-and-add sign-magnitude multiplier serving two requesters,
// one product per MAG_W+2 cycles, result returned via valid/ready.
module mul_seq_sched
    import mul_pkg::*;
#(
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    input  logic [MAG_W:0]   i_req0_A,
    input  logic [MAG_W:0]   i_req0_B,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [MAG_W:0]   i_req1_A,
    input  logic [MAG_W:0]   i_req1_B,
    output logic             o_req1_ready,
    output logic             o_valid,
    output logic [2*MAG_W:0] o_res,
    output logic             o_Z,
    output logic             o_gnt_id,
    input  logic             i_ready
);

    localparam int RES_W = res_width(MAG_W);
    localparam int SGN   = sign_idx(MAG_W);
    localparam int PW    = 2 * MAG_W;
    localparam int CNT_W = $clog2(MAG_W + 1);

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [PW-1:0]      mcand_q, mcand_d;
    logic [MAG_W-1:0]   mplier_q, mplier_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               z_q, z_d;
    logic               vld_q, vld_d;
    logic               id_q, id_d;

    logic [1:0]         req, gnt;
    logic               gnt_id, advance;
    logic [MAG_W:0]     a_sel, b_sel;
    logic [PW-1:0]      acc_step;

    // Requests are only visible to the arbiter while the engine is free.
    assign req     = (state_q == IDLE) ? {i_req1_valid, i_req0_valid} : 2'b00;
    assign advance = |req;

    rr_arb2 u_arb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (req),
        .i_advance (advance),
        .o_gnt     (gnt),
        .o_gnt_id  (gnt_id)
    );

    assign o_req0_ready = gnt[0];
    assign o_req1_ready = gnt[1];
    assign a_sel        = gnt_id ? i_req1_A : i_req0_A;
    assign b_sel        = gnt_id ? i_req1_B : i_req0_B;
    assign acc_step     = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        z_d      = z_q;
        vld_d    = vld_q;
        id_d     = id_q;
        case (state_q)
            IDLE: begin
                if (advance) begin
                    sign_d   = a_sel[SGN] ^ b_sel[SGN];
                    mcand_d  = {{MAG_W{1'b0}}, a_sel[MAG_W-1:0]};
                    mplier_d = b_sel[MAG_W-1:0];
                    acc_d    = '0;
                    cnt_d    = CNT_W'(MAG_W);
                    id_d     = gnt_id;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                // Last step: publish directly from the final sum; -0 becomes +0.
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = {sign_q & (acc_step != '0), acc_step};
                    z_d     = (acc_step == '0);
                    vld_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            z_q      <= 1'b0;
            vld_q    <= 1'b0;
            id_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            z_q      <= z_d;
            vld_q    <= vld_d;
            id_q     <= id_d;
        end
    end

    assign o_valid  = vld_q;
    assign o_res    = res_q;
    assign o_Z      = z_q;
    assign o_gnt_id = id_q;

endmodule

// File: tb/tb_mul_seq_sched.sv
// Scoreboard bench for mul_seq_sched: accepts push model results, a monitor
// compares every presented result against the queue head.
module tb_mul_seq_sched;

    localparam int MW = 2;
    localparam int RW = 2 * MW + 1;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          z;
        logic          id;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          v0, v1;
    logic [MW:0]   a0, b0, a1, b1;
    logic          r0, r1;
    logic          o_valid, o_Z, o_gnt_id;
    logic [RW-1:0] o_res;
    logic          i_ready;
    logic          rdy_rand = 1'b0;
    logic          rdy_man  = 1'b1;
    logic          rdy_rnd  = 1'b1;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic last_id = 1'b1;
    logic prev_valid = 1'b0;

    assign i_ready = rdy_rand ? rdy_rnd : rdy_man;

    mul_seq_sched #(.MAG_W(MW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req0_valid (v0),
        .i_req0_A     (a0),
        .i_req0_B     (b0),
        .o_req0_ready (r0),
        .i_req1_valid (v1),
        .i_req1_A     (a1),
        .i_req1_B     (b1),
        .o_req1_ready (r1),
        .o_valid      (o_valid),
        .o_res        (o_res),
        .o_Z          (o_Z),
        .o_gnt_id     (o_gnt_id),
        .i_ready      (i_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rdy_rnd <= 1'($urandom_range(0, 1));
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer product of magnitudes, sign only on nonzero results.
    function automatic exp_t model(input logic id, input logic [MW:0] a, input logic [MW:0] b);
        int   ma, mb, mag;
        exp_t e;
        ma = int'(a[MW-1:0]);
        mb = int'(b[MW-1:0]);
        mag = ma * mb;
        e.res = RW'(mag);
        e.res[RW-1] = (a[MW] ^ b[MW]) && (mag != 0);
        e.z = (mag == 0);
        e.id = id;
        return e;
    endfunction

    // Accept watcher: checks arbitration and pushes the expected result.
    always @(negedge clk) begin
        logic wid, exp_wid;
        if (!rst_n) begin
            last_id = 1'b1;
        end else if (r0 || r1) begin
            wid = r1;
            exp_wid = (v0 && v1) ? ~last_id : v1;
            check("ready_both", 32'(r0 & r1), 32'd0);
            check("arb_grant", 32'(wid), 32'(exp_wid));
            check("ready_needs_valid", 32'(wid ? v1 : v0), 32'd1);
            exp_q.push_back(model(wid, wid ? a1 : a0, wid ? b1 : b0));
            last_id = wid;
            acc_cyc = cyc;
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (o_valid) begin
                check("ready_in_done", 32'({r1, r0}), 32'd0);
                if (!prev_valid) check("latency", 32'(cyc - acc_cyc), 32'(MW + 1));
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(o_valid), 32'd0);
                end else begin
                    check("res", 32'(o_res), 32'(exp_q[0].res));
                    check("zflag", 32'(o_Z), 32'(exp_q[0].z));
                    check("gnt_id", 32'(o_gnt_id), 32'(exp_q[0].id));
                    if (i_ready) void'(exp_q.pop_front());
                end
            end
            prev_valid = o_valid;
        end
    end

    task automatic issue(input logic id, input logic [MW:0] a, input logic [MW:0] b);
        int n = 0;
        logic got = 1'b0;
        @(posedge clk); #1;
        if (id) begin v1 = 1'b1; a1 = a; b1 = b; end
        else    begin v0 = 1'b1; a0 = a; b0 = b; end
        while (!got && n < 100) begin
            @(negedge clk);
            got = id ? r1 : r0;
            n++;
        end
        check("accept_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        if (id) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic stream(input int n);
        int   got = 0;
        int   guard = 0;
        logic g0, g1;
        @(posedge clk); #1;
        v0 = 1'b1; a0 = 3'($urandom); b0 = 3'($urandom);
        v1 = 1'b1; a1 = 3'($urandom); b1 = 3'($urandom);
        while (got < n && guard < 500) begin
            @(negedge clk);
            g0 = r0;
            g1 = r1;
            guard++;
            if (g0 || g1) begin
                got++;
                @(posedge clk); #1;
                if (g0) begin a0 = 3'($urandom); b0 = 3'($urandom); end
                if (g1) begin a1 = 3'($urandom); b1 = 3'($urandom); end
            end
        end
        v0 = 1'b0;
        v1 = 1'b0;
        check("stream_count", 32'(got), 32'(n));
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", 32'(o_valid), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #2;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_res", 32'(o_res), 32'd0);
        check("rst_z", 32'(o_Z), 32'd0);
        check("rst_gnt_id", 32'(o_gnt_id), 32'd0);
        check("rst_ready", 32'({r1, r0}), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Contention from reset: grants must alternate starting with requester 0.
        stream(8);
        drain();

        issue(1'b0, 3'b111, 3'b110);
        wait_valid();
        check("t1_res", 32'(o_res), 32'b00110);
        check("t1_z", 32'(o_Z), 32'd0);
        check("t1_id", 32'(o_gnt_id), 32'd0);
        drain();

        issue(1'b1, 3'b101, 3'b011);
        wait_valid();
        check("t2_res", 32'(o_res), 32'b10011);
        check("t2_id", 32'(o_gnt_id), 32'd1);
        drain();

        issue(1'b1, 3'b100, 3'b010);
        wait_valid();
        check("negzero_res", 32'(o_res), 32'd0);
        check("negzero_z", 32'(o_Z), 32'd1);
        drain();

        // Downstream stall with a pending requester waiting behind it.
        rdy_man = 1'b0;
        issue(1'b0, 3'b011, 3'b111);
        wait_valid();
        @(posedge clk); #1;
        v1 = 1'b1; a1 = 3'b010; b1 = 3'b011;
        repeat (5) @(posedge clk);
        #1 rdy_man = 1'b1;
        issue(1'b1, 3'b010, 3'b011);
        drain();
        check("hold_last_res", 32'(o_res), 32'b00110);

        // Asynchronous reset in the middle of a calculation.
        issue(1'b0, 3'b011, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_res", 32'(o_res), 32'd0);
        check("arst_z", 32'(o_Z), 32'd0);
        check("arst_gnt_id", 32'(o_gnt_id), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("no_stale", 32'(o_valid), 32'd0);
        stream(2);
        drain();
        issue(1'b0, 3'b010, 3'b111);
        drain();

        // Exhaustive operand sweep, requesters alternating, random backpressure.
        rdy_rand = 1'b1;
        for (int i = 0; i < 64; i++) begin
            issue(1'(i), 3'(i >> 3), 3'(i));
        end
        drain();
        rdy_rand = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_seq_sched.md
Name: mul_seq_sched

Overview:
- Shared, sequential sign-magnitude multiply engine for the arithmetic unit calculator.
- Arbitrates round-robin between two requesters (e.g. keypad/front-end path and test/self-check path) and computes A x B by iterative shift-and-add over MAG_W cycles.
- Returns a sign-magnitude product plus a zero flag through a valid/ready handshake.
- Result format matches the combinational multiplier: MSB is the sign, lower 2*MAG_W bits are the magnitude.

Parameters:
- MAG_W, 2, magnitude bits per operand; operand width is MAG_W+1 (MSB = sign, 1 = negative).
- RES_W, 2*MAG_W+1, result width (derived; not overridable).

Ports:
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req0_valid  in  1  requester 0 has an operand pair.
- i_req0_A  in  MAG_W+1  requester 0 operand A, sign-magnitude.
- i_req0_B  in  MAG_W+1  requester 0 operand B, sign-magnitude.
- o_req0_ready  out  1  requester 0 pair accepted this cycle.
- i_req1_valid  in  1  requester 1 has an operand pair.
- i_req1_A  in  MAG_W+1  requester 1 operand A.
- i_req1_B  in  MAG_W+1  requester 1 operand B.
- o_req1_ready  out  1  requester 1 pair accepted this cycle.
- o_valid  out  1  result available.
- o_res  out  RES_W  product: o_res[RES_W-1] = sign, o_res[RES_W-2:0] = magnitude.
- o_Z  out  1  zero flag; 1 iff the magnitude is 0.
- o_gnt_id  out  1  which requester owns the current result.
- i_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FSM to IDLE; o_valid, o_res, o_Z, o_gnt_id = 0.
  - Accumulator, counter and operand registers cleared.
  - Round-robin pointer set so requester 0 wins first.
  - An operation in flight is discarded; no result is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If no i_reqX_valid, stay in IDLE.
  - If exactly one is valid, that requester is granted.
  - If both are valid, the requester not granted last wins.
  - o_reqX_ready = 1 only for the granted requester, only in IDLE, asserted combinationally in the same cycle as its valid.
  - On the accepting edge, capture:
    - sign = A[MAG_W] ^ B[MAG_W].
    - Multiplicand = A magnitude, zero-extended to 2*MAG_W.
    - Multiplier = B magnitude.
    - acc = 0, cnt = MAG_W, o_gnt_id = grant; update the pointer.
  - Go to CALC.
- CALC, one step per cycle:
  - If multiplier[0], acc <= acc + multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; cnt--.
  - When cnt reaches 1 on the current step, register the results:
    - o_res magnitude = final acc.
    - o_Z = (final acc == 0).
    - o_res sign = sign & ~o_Z; negative zero is normalised to +0.
    - o_valid <= 1; go to DONE.
- DONE:
  - Hold o_valid, o_res, o_Z and o_gnt_id stable while i_ready = 0.
  - On o_valid & i_ready: o_valid <= 0, go to IDLE.
  - No new accept in the same cycle as the result handshake; the earliest accept is the following cycle.
- Latency: accept edge to o_valid high = MAG_W edges. Throughput: one product per MAG_W+2 cycles under continuous i_ready.
- Ready signals are 0 in CALC and DONE; requesters must hold valid and operands until ready.
- Width rules:
  - Accumulator is 2*MAG_W bits and never overflows, since max magnitude (2^MAG_W-1)^2 fits.
  - Result magnitude equals |A|*|B| exactly.
- o_res and o_Z are registered outputs; no combinational path from operand inputs to o_res.

Decomposition:
- Shared package / include `mul_pkg`:
  - State encoding localparams (IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2).
  - MAG_W default; RES_W derivation.
  - Sign-bit index helper constant.
- One sub-module, `rr_arb2`:
  - Two-input round-robin arbiter with pointer register.
  - Inputs: i_clk, i_rst_n, req[1:0], advance. Outputs: gnt[1:0], gnt_id.
  - advance is asserted on the accepting edge.
- The datapath (shift-add) and FSM stay in mul_seq_sched.

Test Plan:
- MAG_W=2, req0 A=111 (-3), B=110 (-2), i_ready=1 -> o_valid high exactly 2 edges after accept; o_res=0_0110, o_Z=0, o_gnt_id=0.
- req1 A=101 (-1), B=011 (+3) -> o_res=1_0011, o_Z=0, o_gnt_id=1. Then A=100 (-0), B=010 -> o_res=0_0000, o_Z=1 (negative zero normalised).
- Both valid every cycle with distinct operands -> grants alternate 0,1,0,1 starting with 0; each ready pulse is one cycle and only in IDLE; the loser's ready stays 0.
- i_ready held 0 for 5 cycles in DONE -> o_valid, o_res, o_Z stable; both ready outputs 0; after i_ready=1, the next accept is no earlier than the following cycle.
- Assert i_rst_n=0 asynchronously mid-CALC (between edges) -> outputs 0 immediately; after release, no stale result; a new req0 completes correctly.
- Exhaustive sweep of all 64 A/B pairs through req0 and req1 alternately -> each result matches the model: magnitude = |A|*|B|, sign = (signA^signB) & (magnitude != 0), Z = (magnitude == 0).
